// File: rtl/priority_intc_seq.sv
// Sequential priority interrupt controller: pending capture (level or edge), per-channel
// enable mask, fixed-priority arbitration and a registered valid/ready presentation.
module priority_intc_seq #(
  parameter int NUM_GRP    = 3,
  parameter int CH_PER_GRP = 9,
  parameter int EDGE_MODE  = 0,
  localparam int N  = NUM_GRP * CH_PER_GRP,
  localparam int CW = (CH_PER_GRP > 2) ? $clog2(CH_PER_GRP) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N-1:0]       req_i,
  input  logic [N-1:0]       en_i,
  output logic               irq_valid_o,
  input  logic               irq_ready_i,
  output logic [NUM_GRP-1:0] irq_grp_o,
  output logic [CW-1:0]      irq_chan_o,
  output logic               irq_any_o,
  output logic [N-1:0]       pending_o,
  output logic               state_o
);

  typedef enum logic {IDLE = 1'b0, PRESENT = 1'b1} state_t;

  state_t               state;
  logic [N-1:0]         pending;
  logic [N-1:0]         hist;
  logic [N-1:0]         sel;
  logic [N-1:0]         set_vec;
  logic [N-1:0]         clr_vec;
  logic [N-1:0]         elig;
  logic [N-1:0]         win_vec;
  logic                 win_found;
  logic [NUM_GRP-1:0]   win_grp;
  logic [CW-1:0]        win_chan;

  assign set_vec = (EDGE_MODE != 0) ? (req_i & ~hist) : req_i;
  assign elig    = pending & en_i;
  // Only the bit actually being presented is cleared; a simultaneous set keeps it pending.
  assign clr_vec = (state == PRESENT && irq_ready_i) ? sel : '0;

  // Flat index order g*CH_PER_GRP+c is exactly priority order, so the first hit wins.
  always_comb begin
    win_found = 1'b0;
    win_vec   = '0;
    win_grp   = '0;
    win_chan  = '0;
    for (int g = 0; g < NUM_GRP; g++) begin
      for (int c = 0; c < CH_PER_GRP; c++) begin
        if (!win_found && elig[g*CH_PER_GRP + c]) begin
          win_found                  = 1'b1;
          win_vec[g*CH_PER_GRP + c]  = 1'b1;
          win_grp[g]                 = 1'b1;
          win_chan                   = CW'(c);
        end
      end
    end
  end

  // Handshake: irq_valid_o rises from IDLE and then holds grp/chan stable until a cycle
  // with irq_ready_i=1; that cycle is the transfer, after which valid drops for at least
  // one cycle. irq_ready_i has no effect while valid is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      pending     <= '0;
      hist        <= req_i;
      sel         <= '0;
      irq_valid_o <= 1'b0;
      irq_grp_o   <= '0;
      irq_chan_o  <= '0;
    end else begin
      hist    <= req_i;
      pending <= (pending & ~clr_vec) | set_vec;
      case (state)
        IDLE: begin
          if (win_found) begin
            state       <= PRESENT;
            sel         <= win_vec;
            irq_valid_o <= 1'b1;
            irq_grp_o   <= win_grp;
            irq_chan_o  <= win_chan;
          end
        end
        PRESENT: begin
          if (irq_ready_i) begin
            state       <= IDLE;
            sel         <= '0;
            irq_valid_o <= 1'b0;
            irq_grp_o   <= '0;
            irq_chan_o  <= '0;
          end
        end
      endcase
    end
  end

  assign irq_any_o = |elig;
  assign pending_o = pending;
  assign state_o   = (state == PRESENT);

endmodule

// File: tb/tb_priority_intc_seq.sv
// Bench for priority_intc_seq: level and edge instances side by side, a directed vector
// table, hand-written multi-cycle sequences and a randomized run against a flat-index model.
module tb_priority_intc_seq;

  localparam int NG = 3;
  localparam int CH = 9;
  localparam int N  = NG * CH;
  localparam logic [N-1:0] ALL = {N{1'b1}};

  logic          clk;
  logic          rst;
  logic [N-1:0]  req;
  logic [N-1:0]  en;
  logic          ready;

  logic          l_valid, l_any, l_state;
  logic [NG-1:0] l_grp;
  logic [3:0]    l_chan;
  logic [N-1:0]  l_pend;
  logic          e_valid, e_any, e_state;
  logic [NG-1:0] e_grp;
  logic [3:0]    e_chan;
  logic [N-1:0]  e_pend;

  int n_checks = 0;
  int n_errors = 0;

  priority_intc_seq #(.NUM_GRP(NG), .CH_PER_GRP(CH), .EDGE_MODE(0)) dut_lvl (
    .clk(clk), .rst(rst), .req_i(req), .en_i(en),
    .irq_valid_o(l_valid), .irq_ready_i(ready), .irq_grp_o(l_grp),
    .irq_chan_o(l_chan), .irq_any_o(l_any), .pending_o(l_pend), .state_o(l_state)
  );

  priority_intc_seq #(.NUM_GRP(NG), .CH_PER_GRP(CH), .EDGE_MODE(1)) dut_edge (
    .clk(clk), .rst(rst), .req_i(req), .en_i(en),
    .irq_valid_o(e_valid), .irq_ready_i(ready), .irq_grp_o(e_grp),
    .irq_chan_o(e_chan), .irq_any_o(e_any), .pending_o(e_pend), .state_o(e_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: k=0 level instance, k=1 edge instance
  logic [N-1:0] m_pend [2];
  logic [N-1:0] m_hist [2];
  bit           m_pres [2];
  int           m_idx  [2];

  function automatic logic [N-1:0] bv(input int i);
    logic [N-1:0] one;
    one = 1;
    return one << i;
  endfunction

  task automatic model_step();
    logic [N-1:0] nxt;
    int first;
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_pend[k] = '0;
        m_hist[k] = req;
        m_pres[k] = 0;
        m_idx[k]  = 0;
      end else begin
        first = -1;
        for (int i = 0; i < N; i++)
          if (first < 0 && m_pend[k][i] && en[i]) first = i;
        nxt = m_pend[k];
        if (m_pres[k]) begin
          if (ready) begin
            nxt[m_idx[k]] = 1'b0;
            m_pres[k] = 0;
          end
        end else if (first >= 0) begin
          m_pres[k] = 1;
          m_idx[k]  = first;
        end
        for (int i = 0; i < N; i++)
          if (req[i] && (k == 0 || !m_hist[k][i])) nxt[i] = 1'b1;
        m_pend[k] = nxt;
        m_hist[k] = req;
      end
    end
  endtask

  // scoreboard
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_model(input int k, input int cyc);
    logic [NG-1:0] g;
    logic [3:0]    c;
    g = m_pres[k] ? NG'(1 << (m_idx[k] / CH)) : '0;
    c = m_pres[k] ? 4'(m_idx[k] % CH) : '0;
    if (k == 0) begin
      check($sformatf("rnd%0d lvl valid", cyc), 64'(l_valid), 64'(m_pres[k]));
      check($sformatf("rnd%0d lvl grp", cyc), 64'(l_grp), 64'(g));
      check($sformatf("rnd%0d lvl chan", cyc), 64'(l_chan), 64'(c));
      check($sformatf("rnd%0d lvl pend", cyc), 64'(l_pend), 64'(m_pend[k]));
      check($sformatf("rnd%0d lvl any", cyc), 64'(l_any), 64'(|(m_pend[k] & en)));
    end else begin
      check($sformatf("rnd%0d edge valid", cyc), 64'(e_valid), 64'(m_pres[k]));
      check($sformatf("rnd%0d edge grp", cyc), 64'(e_grp), 64'(g));
      check($sformatf("rnd%0d edge chan", cyc), 64'(e_chan), 64'(c));
      check($sformatf("rnd%0d edge pend", cyc), 64'(e_pend), 64'(m_pend[k]));
      check($sformatf("rnd%0d edge any", cyc), 64'(e_any), 64'(|(m_pend[k] & en)));
    end
  endtask

  // driver: inputs change on the falling edge, outputs sampled 1 time unit after rising edge
  task automatic drive(input logic r, input logic [N-1:0] q, input logic [N-1:0] e,
                       input logic rd);
    @(negedge clk);
    rst   = r;
    req   = q;
    en    = e;
    ready = rd;
    @(posedge clk);
    model_step();
    #1;
  endtask

  typedef struct {
    logic [N-1:0]  req;
    logic [N-1:0]  en;
    logic          ready;
    logic          exp_valid;
    logic [NG-1:0] exp_grp;
    logic [3:0]    exp_chan;
    logic          exp_any;
    logic [N-1:0]  exp_pend;
  } vec_t;

  vec_t tbl [17];

  function automatic vec_t mk(input logic [N-1:0] q, input logic [N-1:0] e, input logic rd,
                              input logic v, input logic [NG-1:0] g, input logic [3:0] c,
                              input logic a, input logic [N-1:0] p);
    vec_t t;
    t.req = q; t.en = e; t.ready = rd; t.exp_valid = v;
    t.exp_grp = g; t.exp_chan = c; t.exp_any = a; t.exp_pend = p;
    return t;
  endfunction

  initial begin
    logic [N-1:0] rq, re;
    rst = 1'b1; req = '0; en = ALL; ready = 1'b0;

    // reset state of both instances
    drive(1'b1, '0, ALL, 1'b0);
    check("rst lvl valid", 64'(l_valid), 64'd0);
    check("rst lvl grp", 64'(l_grp), 64'd0);
    check("rst lvl chan", 64'(l_chan), 64'd0);
    check("rst lvl pend", 64'(l_pend), 64'd0);
    check("rst edge valid", 64'(e_valid), 64'd0);
    check("rst edge pend", 64'(e_pend), 64'd0);

    // level-mode table: two-request ordering, no preemption, enable mask
    tbl[0]  = mk(bv(10) | bv(20), ALL, 0, 0, 3'b000, 0, 1, bv(10) | bv(20));
    tbl[1]  = mk(bv(10) | bv(20), ALL, 0, 1, 3'b010, 1, 1, bv(10) | bv(20));
    tbl[2]  = mk('0, ALL, 1, 0, 3'b000, 0, 1, bv(20));
    tbl[3]  = mk('0, ALL, 0, 1, 3'b100, 2, 1, bv(20));
    tbl[4]  = mk('0, ALL, 1, 0, 3'b000, 0, 0, '0);
    tbl[5]  = mk('0, ALL, 0, 0, 3'b000, 0, 0, '0);
    tbl[6]  = mk(bv(20), ALL, 0, 0, 3'b000, 0, 1, bv(20));
    tbl[7]  = mk('0, ALL, 0, 1, 3'b100, 2, 1, bv(20));
    tbl[8]  = mk(bv(0), ALL, 0, 1, 3'b100, 2, 1, bv(20) | bv(0));
    tbl[9]  = mk('0, ALL, 0, 1, 3'b100, 2, 1, bv(20) | bv(0));
    tbl[10] = mk('0, ALL, 1, 0, 3'b000, 0, 1, bv(0));
    tbl[11] = mk('0, ALL, 0, 1, 3'b001, 0, 1, bv(0));
    tbl[12] = mk('0, ALL, 1, 0, 3'b000, 0, 0, '0);
    tbl[13] = mk(bv(3), ALL & ~bv(3), 0, 0, 3'b000, 0, 0, bv(3));
    tbl[14] = mk('0, ALL & ~bv(3), 0, 0, 3'b000, 0, 0, bv(3));
    tbl[15] = mk('0, ALL, 0, 1, 3'b001, 3, 1, bv(3));
    tbl[16] = mk('0, ALL, 1, 0, 3'b000, 0, 0, '0);
    for (int r = 0; r < 17; r++) begin
      drive(1'b0, tbl[r].req, tbl[r].en, tbl[r].ready);
      check($sformatf("tbl%0d valid", r), 64'(l_valid), 64'(tbl[r].exp_valid));
      check($sformatf("tbl%0d grp", r), 64'(l_grp), 64'(tbl[r].exp_grp));
      check($sformatf("tbl%0d chan", r), 64'(l_chan), 64'(tbl[r].exp_chan));
      check($sformatf("tbl%0d any", r), 64'(l_any), 64'(tbl[r].exp_any));
      check($sformatf("tbl%0d pend", r), 64'(l_pend), 64'(tbl[r].exp_pend));
    end

    // edge mode: request high through reset is not an edge
    drive(1'b1, ALL, ALL, 1'b0);
    drive(1'b0, ALL, ALL, 1'b0);
    check("e1 pend after rst", 64'(e_pend), 64'd0);
    check("e1 valid after rst", 64'(e_valid), 64'd0);
    drive(1'b0, ALL & ~bv(4), ALL, 1'b0);
    check("e1 pend after drop", 64'(e_pend), 64'd0);
    drive(1'b0, ALL, ALL, 1'b0);
    check("e1 pend after rise", 64'(e_pend), 64'h10);
    check("e1 valid early", 64'(e_valid), 64'd0);
    drive(1'b0, ALL, ALL, 1'b0);
    check("e1 valid", 64'(e_valid), 64'd1);
    check("e1 grp", 64'(e_grp), 64'b001);
    check("e1 chan", 64'(e_chan), 64'd4);

    // edge mode: new rising edge in the ack cycle keeps the bit pending
    drive(1'b0, ALL & ~bv(4), ALL, 1'b0);
    check("e5 hold valid", 64'(e_valid), 64'd1);
    drive(1'b0, ALL, ALL, 1'b1);
    check("e5 ack valid", 64'(e_valid), 64'd0);
    check("e5 ack state", 64'(e_state), 64'd0);
    check("e5 ack pend", 64'(e_pend), 64'h10);
    drive(1'b0, ALL, ALL, 1'b0);
    check("e5 regrant valid", 64'(e_valid), 64'd1);
    check("e5 regrant grp", 64'(e_grp), 64'b001);
    check("e5 regrant chan", 64'(e_chan), 64'd4);
    drive(1'b0, ALL, ALL, 1'b1);
    check("e5 final valid", 64'(e_valid), 64'd0);
    check("e5 final pend", 64'(e_pend), 64'd0);

    // reset while presenting with ready high
    drive(1'b0, ALL & ~bv(5), ALL, 1'b0);
    drive(1'b0, ALL, ALL, 1'b0);
    drive(1'b0, ALL, ALL, 1'b0);
    check("e6 present valid", 64'(e_valid), 64'd1);
    check("e6 present chan", 64'(e_chan), 64'd5);
    check("e6 present state", 64'(e_state), 64'd1);
    drive(1'b1, ALL, ALL, 1'b1);
    check("e6 rst valid", 64'(e_valid), 64'd0);
    check("e6 rst grp", 64'(e_grp), 64'd0);
    check("e6 rst chan", 64'(e_chan), 64'd0);
    check("e6 rst pend", 64'(e_pend), 64'd0);
    check("e6 rst state", 64'(e_state), 64'd0);
    check("e6 rst lvl pend", 64'(l_pend), 64'd0);
    drive(1'b0, ALL, ALL, 1'b0);
    check("e6 idle after rst", 64'(e_valid), 64'd0);
    check("e6 pend after rst", 64'(e_pend), 64'd0);

    // randomized run against the model
    drive(1'b1, '0, ALL, 1'b0);
    for (int cyc = 0; cyc < 600; cyc++) begin
      for (int i = 0; i < N; i++) begin
        rq[i] = ($urandom_range(0, 7) == 0);
        re[i] = ($urandom_range(0, 7) != 0);
      end
      drive(($urandom_range(0, 63) == 0), rq, re, 1'($urandom_range(0, 1)));
      check_model(0, cyc);
      check_model(1, cyc);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/priority_intc_seq.md
Name: priority_intc_seq

Overview:
- Sequential, parametrised interrupt controller: NUM_GRP buses × CH_PER_GRP request channels.
- Latches requests into a pending register (level or edge mode) and applies a per-channel enable mask.
- Arbitrates by fixed priority: group 0 highest; within a group, lowest channel index highest.
- Presents the winner on a valid/ready handshake, with one-hot group and binary channel code.
- Successor to the team's combinational 27-channel (3×9) priority decoder: adds storage, masking, modes and handshake.

Parameters:
- NUM_GRP, 3, number of request buses (≥1)
- CH_PER_GRP, 9, channels per bus (≥2)
- EDGE_MODE, 0, 0 = level-sensitive pending set; 1 = rising-edge set
- Derived, not overridable: N = NUM_GRP*CH_PER_GRP; CW = max(1, clog2(CH_PER_GRP))

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- req_i  in  N  raw requests; bit g*CH_PER_GRP+c = group g, channel c
- en_i  in  N  per-channel enable mask; 1 = eligible
- irq_valid_o  out  1  presented interrupt valid (registered)
- irq_ready_i  in  1  consumer acknowledge
- irq_grp_o  out  NUM_GRP  one-hot winning group (registered; 0 when not valid)
- irq_chan_o  out  CW  winning channel index within group (registered; 0 when not valid)
- irq_any_o  out  1  combinational OR of (pending & en_i)
- pending_o  out  N  pending register contents

Behaviour:
Reset (rst=1 at clock edge):
- pending=0, irq_valid_o=0, irq_grp_o=0, irq_chan_o=0, state=IDLE.
- Edge-history register loads req_i, so a request already high out of reset is not an edge.
- Reset overrides everything, including a handshake in the same cycle.

Pending set:
- Level mode: pending[i] set on any clock where req_i[i]=1.
- Edge mode: set when req_i[i]=1 and hist[i]=0. hist <= req_i every cycle.
- Pending is sticky until cleared by a grant; it is never cleared by req_i falling.

Eligibility and arbitration (combinational):
- elig = pending & en_i.
- Winner = lowest g with any elig bit in group g; within it, the lowest c.

FSM (states IDLE, PRESENT):
- IDLE: if elig≠0, register the winner into irq_grp_o/irq_chan_o, set irq_valid_o=1, go to PRESENT. Otherwise stay.
- PRESENT: outputs held stable regardless of new requests, mask changes or higher-priority arrivals (no preemption).
- PRESENT with irq_ready_i=1: clear the winner's pending bit, drive irq_valid_o=0 and both codes to 0 next cycle, go to IDLE.
- irq_ready_i is ignored in IDLE.

Simultaneous events:
- Clear of bit i and set of bit i in the same cycle: set wins, so the bit stays pending. In level mode, a still-asserted request re-pends immediately.
- The winner's mask dropping while PRESENT does not cancel the presentation.

Latency and throughput:
- Level request at cycle t → pending at t+1 → irq_valid_o at t+2 (if IDLE and highest priority).
- Back-to-back grants are separated by at least one IDLE cycle, so max throughput is 1 grant per 2 cycles.

irq_any_o reflects the current pending & en_i, including the presented bit until its pending bit is cleared.

Test Plan:
1. Reset with req_i all 1, EDGE_MODE=1, 3×9 → after release, pending_o=0, irq_valid_o=0. Drop bit 4 then raise it → pending_o=0x10, and two cycles after the rise irq_valid_o=1, irq_grp_o=3'b001, irq_chan_o=4.
2. Level mode, req bits 20 (g2,c2) and 10 (g1,c1) raised together, all enabled → first grant grp=3'b010, chan=1. After ready, second grant grp=3'b100, chan=2. pending_o=0 after the second ack once req_i is dropped.
3. While presenting g2,c2, raise bit 0 → outputs unchanged until ready. Next grant is grp=3'b001, chan=0.
4. en_i bit 3=0 with pending bit 3 set → irq_any_o=0, no valid. Set en bit 3 → valid after 1 cycle, chan=3.
5. Edge mode, new rising edge on the presented channel in the ack cycle → bit stays pending and is re-granted after one IDLE cycle.
6. Assert rst while PRESENT with irq_ready_i=1 → next cycle all outputs 0, pending_o=0, state IDLE.
